// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single data-memory port between instruction fetch (IF) and the
// load/store unit (LS). Exactly one transaction is in flight at a time: the
// arbiter picks a winner in IDLE, latches its request, presents it to memory
// in ISSUE until memory accepts, then waits in WAIT for the response and
// hands it back to the owner as a one-cycle registered pulse.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  undefined -> fixed priority, LS wins a tie
//                       defined   -> the requester that was not granted last
//                                    wins a tie (last_grant updates per grant)
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width; byte-enable width is DATA_W/8
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_if_req_valid       fetch read request
//   i_if_req_addr        fetch address
//   o_if_req_ready       fetch request accepted this cycle
//   o_if_resp_valid      one-cycle pulse, o_if_resp_rdata valid
//   o_if_resp_rdata      fetch read data (held between pulses)
//   i_ls_req_valid       load/store request
//   i_ls_req_addr        effective address
//   i_ls_req_wdata       lane-replicated store data
//   i_ls_req_we          byte enables, all zero means load
//   o_ls_req_ready       load/store request accepted this cycle
//   o_ls_resp_valid      one-cycle pulse, load data / store acknowledge
//   o_ls_resp_rdata      raw read data, zero for stores (held between pulses)
//   o_mem_req_valid      request to memory
//   i_mem_req_ready      memory accepts the request
//   o_mem_addr           latched address
//   o_mem_wdata          latched write data
//   o_mem_we             latched byte enables, always zero for fetches
//   i_mem_resp_valid     memory response (reads and writes)
//   i_mem_rdata          memory read data
//   o_busy               high whenever the arbiter is not IDLE
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_if_req_valid,
    input  logic [ADDR_W-1:0]   i_if_req_addr,
    output logic                o_if_req_ready,
    output logic                o_if_resp_valid,
    output logic [DATA_W-1:0]   o_if_resp_rdata,

    input  logic                i_ls_req_valid,
    input  logic [ADDR_W-1:0]   i_ls_req_addr,
    input  logic [DATA_W-1:0]   i_ls_req_wdata,
    input  logic [DATA_W/8-1:0] i_ls_req_we,
    output logic                o_ls_req_ready,
    output logic                o_ls_resp_valid,
    output logic [DATA_W-1:0]   o_ls_resp_rdata,

    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_we,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,

    output logic                o_busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t              r_state;
    state_t              w_next_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_we;

    logic                r_if_resp_valid;
    logic [DATA_W-1:0]   r_if_resp_rdata;
    logic                r_ls_resp_valid;
    logic [DATA_W-1:0]   r_ls_resp_rdata;

    logic                w_grant;
    logic                w_grant_ls;
    logic                w_resp_take;
    logic [DATA_W-1:0]   w_resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t              r_last_grant;
`endif

    // Winner selection. Grants are only possible in IDLE and are suppressed
    // while reset is asserted so that no request is consumed by a cycle whose
    // state update is about to be discarded.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_ls = 1'b0;
        if ((r_state == ST_IDLE) && !i_rst) begin
            w_grant = i_if_req_valid | i_ls_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
            // On a tie, LS wins only if IF was the previous grantee.
            w_grant_ls = i_ls_req_valid &
                         (!i_if_req_valid || (r_last_grant == OWN_IF));
`else
            w_grant_ls = i_ls_req_valid;
`endif
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state    = r_state;
        o_if_req_ready  = 1'b0;
        o_ls_req_ready  = 1'b0;
        o_mem_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    o_ls_req_ready = w_grant_ls;
                    o_if_req_ready = !w_grant_ls;
                    w_next_state   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_resp_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A response only counts while waiting for one; stray responses in any
    // other state fall through untouched. Stores return zero, not whatever
    // the memory happens to drive on its read bus.
    assign w_resp_take = (r_state == ST_WAIT) && i_mem_resp_valid;
    assign w_resp_data = (r_we != '0) ? '0 : i_mem_rdata;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch: captures the winner's fields at grant time and holds
    // them stable for the whole ISSUE/WAIT period.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= '0;
        end else if (w_grant) begin
            if (w_grant_ls) begin
                r_owner <= OWN_LS;
                r_addr  <= i_ls_req_addr;
                r_wdata <= i_ls_req_wdata;
                r_we    <= i_ls_req_we;
            end else begin
                r_owner <= OWN_IF;
                r_addr  <= i_if_req_addr;
                r_wdata <= '0;
                r_we    <= '0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Tie-break history, updated on every grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= OWN_IF;
        end else if (w_grant) begin
            r_last_grant <= w_grant_ls ? OWN_LS : OWN_IF;
        end
    end
`endif

    // Response routing. The valid flags default low every cycle so each
    // response produces exactly one pulse; the data registers only change
    // when their owner receives a response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_if_resp_valid <= 1'b0;
            r_if_resp_rdata <= '0;
            r_ls_resp_valid <= 1'b0;
            r_ls_resp_rdata <= '0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;
            if (w_resp_take) begin
                if (r_owner == OWN_LS) begin
                    r_ls_resp_valid <= 1'b1;
                    r_ls_resp_rdata <= w_resp_data;
                end else begin
                    r_if_resp_valid <= 1'b1;
                    r_if_resp_rdata <= w_resp_data;
                end
            end
        end
    end

    assign o_if_resp_valid = r_if_resp_valid;
    assign o_if_resp_rdata = r_if_resp_rdata;
    assign o_ls_resp_valid = r_ls_resp_valid;
    assign o_ls_resp_rdata = r_ls_resp_rdata;

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_we    = r_we;

    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Testbench for mem_port_arbiter. A small memory model answers requests with
// configurable stall and response delay; requesters are driven by tasks; every
// accepted request pushes its expected response into a scoreboard that is
// popped when the arbiter pulses a resp_valid. Tie-break expectations follow
// ARB_ROUND_ROBIN_EN when it is defined for the build.
// ============================================================================
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        ifReqValid;
    logic [63:0] ifReqAddr;
    logic        ifReqReady;
    logic        ifRespValid;
    logic [63:0] ifRespRdata;

    logic        lsReqValid;
    logic [63:0] lsReqAddr;
    logic [63:0] lsReqWdata;
    logic [7:0]  lsReqWe;
    logic        lsReqReady;
    logic        lsRespValid;
    logic [63:0] lsRespRdata;

    logic        memReqValid;
    logic        memReqReady;
    logic [63:0] memAddr;
    logic [63:0] memWdata;
    logic [7:0]  memWe;
    logic        memRespValid;
    logic [63:0] memRdata;

    logic        busy;

    typedef struct {
        bit          isLs;
        logic [63:0] data;
    } expResp_t;

    expResp_t    sbQ[$];
    bit          grantLog[$];
    int          acceptCycle[$];
    int          respCycle[$];

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycleCnt    = 0;

    bit          memAuto  = 1'b0;
    int          memStall = 0;
    int          memDelay = 0;
    int          lastStall = 0;
    logic [63:0] capAddr;
    logic [63:0] capWdata;
    logic [7:0]  capWe;

    mem_port_arbiter #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .i_clk            (clock),
        .i_rst            (reset),
        .i_if_req_valid   (ifReqValid),
        .i_if_req_addr    (ifReqAddr),
        .o_if_req_ready   (ifReqReady),
        .o_if_resp_valid  (ifRespValid),
        .o_if_resp_rdata  (ifRespRdata),
        .i_ls_req_valid   (lsReqValid),
        .i_ls_req_addr    (lsReqAddr),
        .i_ls_req_wdata   (lsReqWdata),
        .i_ls_req_we      (lsReqWe),
        .o_ls_req_ready   (lsReqReady),
        .o_ls_resp_valid  (lsRespValid),
        .o_ls_resp_rdata  (lsRespRdata),
        .o_mem_req_valid  (memReqValid),
        .i_mem_req_ready  (memReqReady),
        .o_mem_addr       (memAddr),
        .o_mem_wdata      (memWdata),
        .o_mem_we         (memWe),
        .i_mem_resp_valid (memRespValid),
        .i_mem_rdata      (memRdata),
        .o_busy           (busy)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Contents of the modelled memory for a given address.
    function automatic logic [63:0] memData(input logic [63:0] a);
        if (a == 64'h1000) return 64'h0000_0000_DEAD_BEEF;
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    task automatic runCycleCounter();
        forever begin
            @(posedge clock);
            cycleCnt++;
        end
    endtask

    // Memory model: stalls mem_req_ready for memStall cycles, checks that the
    // request fields do not move while stalled, then responds memDelay cycles
    // after the handshake. It always drives read data, even for stores.
    task automatic runMemModel();
        int phase    = 0;
        int stallCnt = 0;
        int delayCnt = 0;
        forever begin
            @(negedge clock);
            if (!memAuto) begin
                phase    = 0;
                stallCnt = 0;
            end else begin
                memRespValid = 1'b0;
                if (phase == 0) begin
                    if (memReqValid) begin
                        if (stallCnt == 0) begin
                            capAddr  = memAddr;
                            capWdata = memWdata;
                            capWe    = memWe;
                        end else begin
                            assertCount++;
                            if (memAddr !== capAddr || memWdata !== capWdata || memWe !== capWe) begin
                                failCount++;
                                $display("[TB] FAIL stall_stable: addr=%h wdata=%h we=%h, expected addr=%h wdata=%h we=%h",
                                         memAddr, memWdata, memWe, capAddr, capWdata, capWe);
                            end
                        end
                        if (stallCnt >= memStall) begin
                            memReqReady = 1'b1;
                            lastStall   = stallCnt;
                            phase       = 1;
                            delayCnt    = 0;
                        end else begin
                            memReqReady = 1'b0;
                            stallCnt++;
                        end
                    end else begin
                        memReqReady = 1'b0;
                        stallCnt    = 0;
                    end
                end else begin
                    memReqReady = 1'b0;
                    if (delayCnt >= memDelay) begin
                        memRespValid = 1'b1;
                        memRdata     = memData(capAddr);
                        phase        = 0;
                        stallCnt     = 0;
                    end else begin
                        delayCnt++;
                    end
                end
            end
        end
    endtask

    // Watches grants: pushes the expected response for each accepted request
    // and checks that grants are exclusive and only happen while idle.
    task automatic runAcceptMonitor();
        forever begin
            @(negedge clock);
            if (ifReqReady || lsReqReady) begin
                assertCount++;
                if ((ifReqReady && lsReqReady) || busy) begin
                    failCount++;
                    $display("[TB] FAIL grant_excl: if_ready=%0b ls_ready=%0b busy=%0b, expected one ready while idle",
                             ifReqReady, lsReqReady, busy);
                end
                if (lsReqReady && lsReqValid) begin
                    sbQ.push_back('{isLs: 1'b1, data: (lsReqWe != 8'h00) ? 64'h0 : memData(lsReqAddr)});
                    grantLog.push_back(1'b1);
                    acceptCycle.push_back(cycleCnt);
                end else if (ifReqReady && ifReqValid) begin
                    sbQ.push_back('{isLs: 1'b0, data: memData(ifReqAddr)});
                    grantLog.push_back(1'b0);
                    acceptCycle.push_back(cycleCnt);
                end
            end
        end
    endtask

    // Scoreboard consumer: each resp_valid pulse must match the oldest
    // outstanding request in owner and data.
    task automatic runRespChecker();
        expResp_t    e;
        bit          gotLs;
        logic [63:0] gotData;
        forever begin
            @(negedge clock);
            if (ifRespValid || lsRespValid) begin
                assertCount++;
                respCycle.push_back(cycleCnt);
                if (ifRespValid && lsRespValid) begin
                    failCount++;
                    $display("[TB] FAIL resp_excl: if_resp_valid=1 ls_resp_valid=1, expected only one");
                end else if (sbQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL resp_unexpected: if_resp_valid=%0b ls_resp_valid=%0b, expected no response",
                             ifRespValid, lsRespValid);
                end else begin
                    e       = sbQ.pop_front();
                    gotLs   = lsRespValid;
                    gotData = gotLs ? lsRespRdata : ifRespRdata;
                    if (gotLs !== e.isLs || gotData !== e.data) begin
                        failCount++;
                        $display("[TB] FAIL resp_data: owner_ls=%0b data=%h, expected owner_ls=%0b data=%h",
                                 gotLs, gotData, e.isLs, e.data);
                    end
                end
            end
        end
    endtask

    // Drives one request and holds it until accepted. Called just after a
    // rising edge; returns just after the rising edge that accepted it.
    task automatic applyStimulus(input bit isLs, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] we);
        bit accepted = 1'b0;
        if (isLs) begin
            lsReqValid = 1'b1;
            lsReqAddr  = addr;
            lsReqWdata = wdata;
            lsReqWe    = we;
        end else begin
            ifReqValid = 1'b1;
            ifReqAddr  = addr;
        end
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clock);
            accepted = isLs ? lsReqReady : ifReqReady;
            @(posedge clock);
            #1;
        end
        if (isLs) lsReqValid = 1'b0;
        else      ifReqValid = 1'b0;
        assertCount++;
        if (!accepted) begin
            failCount++;
            $display("[TB] FAIL req_accept: ls=%0b addr=%h not accepted, expected acceptance within 200 cycles",
                     isLs, addr);
        end
    endtask

    // Waits (bounded) until nothing is outstanding and the arbiter is idle.
    task automatic waitDrain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clock);
            if (sbQ.size() == 0 && !busy) ok = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        ifReqValid   = 1'b0;
        ifReqAddr    = '0;
        lsReqValid   = 1'b0;
        lsReqAddr    = '0;
        lsReqWdata   = '0;
        lsReqWe      = '0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRdata     = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        assertCount++;
        if (busy !== 1'b0 || memReqValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_state: busy=%b mem_req_valid=%b, expected 0 0", busy, memReqValid);
        end
        assertCount++;
        if (ifReqReady !== 1'b0 || lsReqReady !== 1'b0 || ifRespValid !== 1'b0 || lsRespValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_hs: if_ready=%b ls_ready=%b if_resp=%b ls_resp=%b, expected all 0",
                     ifReqReady, lsReqReady, ifRespValid, lsRespValid);
        end
        assertCount++;
        if (memAddr !== 64'h0 || memWdata !== 64'h0 || memWe !== 8'h0) begin
            failCount++;
            $display("[TB] FAIL reset_latch: addr=%h wdata=%h we=%h, expected all 0", memAddr, memWdata, memWe);
        end
        assertCount++;
        if (ifRespRdata !== 64'h0 || lsRespRdata !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL reset_rdata: if=%h ls=%h, expected 0 0", ifRespRdata, lsRespRdata);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_fetch();
        bit ok;
        memAuto  = 1'b1;
        memStall = 0;
        memDelay = 1;
        grantLog.delete();
        acceptCycle.delete();
        respCycle.delete();
        applyStimulus(1'b0, 64'h1000, 64'h0, 8'h00);
        waitDrain(ok);
        assertCount++;
        if (!ok || grantLog.size() != 1 || respCycle.size() != 1) begin
            failCount++;
            $display("[TB] FAIL fetch_done: drained=%0b grants=%0d resps=%0d, expected 1 1 1",
                     ok, grantLog.size(), respCycle.size());
        end
        assertCount++;
        if (capAddr !== 64'h1000 || capWe !== 8'h00 || capWdata !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL fetch_fields: addr=%h we=%h wdata=%h, expected 1000 00 0", capAddr, capWe, capWdata);
        end
        assertCount++;
        if (ifRespRdata !== 64'h0000_0000_DEAD_BEEF) begin
            failCount++;
            $display("[TB] FAIL fetch_hold: if_resp_rdata=%h, expected deadbeef", ifRespRdata);
        end
        assertCount++;
        if (respCycle.size() != 1 || acceptCycle.size() != 1 || respCycle[0] - acceptCycle[0] != 4) begin
            failCount++;
            $display("[TB] FAIL fetch_latency: %0d cycles, expected 4",
                     (respCycle.size() > 0 && acceptCycle.size() > 0) ? respCycle[0] - acceptCycle[0] : -1);
        end
    endtask

    task automatic test_store();
        bit ok;
        memAuto  = 1'b1;
        memStall = 3;
        memDelay = 1;
        grantLog.delete();
        applyStimulus(1'b1, 64'h2004, 64'h1122_3344_5566_7788, 8'h0F);
        waitDrain(ok);
        assertCount++;
        if (!ok || grantLog.size() != 1 || grantLog[0] !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL store_done: drained=%0b grants=%0d, expected 1 1 (LS)", ok, grantLog.size());
        end
        assertCount++;
        if (lastStall != 3) begin
            failCount++;
            $display("[TB] FAIL store_stall: stalled %0d cycles, expected 3", lastStall);
        end
        assertCount++;
        if (capAddr !== 64'h2004 || capWe !== 8'h0F || capWdata !== 64'h1122_3344_5566_7788) begin
            failCount++;
            $display("[TB] FAIL store_fields: addr=%h we=%h wdata=%h, expected 2004 0f 1122334455667788",
                     capAddr, capWe, capWdata);
        end
        assertCount++;
        if (lsRespRdata !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL store_rdata: ls_resp_rdata=%h, expected 0", lsRespRdata);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        bit expFirstLs;
`ifdef ARB_ROUND_ROBIN_EN
        expFirstLs = 1'b0;
`else
        expFirstLs = 1'b1;
`endif
        memAuto  = 1'b1;
        memStall = 0;
        memDelay = 0;
        grantLog.delete();
        acceptCycle.delete();
        respCycle.delete();
        fork
            applyStimulus(1'b0, 64'h3000, 64'h0, 8'h00);
            applyStimulus(1'b1, 64'h4000, 64'hCAFE_F00D_1234_5678, 8'h00);
        join
        waitDrain(ok);
        assertCount++;
        if (!ok || grantLog.size() != 2) begin
            failCount++;
            $display("[TB] FAIL simul_done: drained=%0b grants=%0d, expected 1 2", ok, grantLog.size());
        end
        assertCount++;
        if (grantLog.size() != 2 || grantLog[0] !== expFirstLs || grantLog[1] !== !expFirstLs) begin
            failCount++;
            $display("[TB] FAIL simul_order: first_ls=%0b, expected %0b",
                     (grantLog.size() > 0) ? grantLog[0] : 1'b0, expFirstLs);
        end
        assertCount++;
        if (acceptCycle.size() != 2 || acceptCycle[1] - acceptCycle[0] != 3) begin
            failCount++;
            $display("[TB] FAIL simul_gap: accepts=%0d, expected 2 accepts 3 cycles apart", acceptCycle.size());
        end
        assertCount++;
        if (respCycle.size() != 2 || acceptCycle.size() != 2 || respCycle[0] - acceptCycle[0] != 3) begin
            failCount++;
            $display("[TB] FAIL simul_latency: resps=%0d, expected first response 3 cycles after accept",
                     respCycle.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        memAuto  = 1'b1;
        memStall = 0;
        memDelay = 0;
        grantLog.delete();
        acceptCycle.delete();
        respCycle.delete();
        fork
            begin
                for (int i = 0; i < 5; i++)
                    applyStimulus(1'b1, 64'h5000 + 64'(i * 8), 64'h0101_0101_0101_0101 * 64'(i + 1),
                                  (i % 2 == 1) ? 8'hFF : 8'h00);
            end
            begin
                for (int i = 0; i < 5; i++)
                    applyStimulus(1'b0, 64'h6000 + 64'(i * 4), 64'h0, 8'h00);
            end
        join
        waitDrain(ok);
        assertCount++;
        if (!ok || grantLog.size() != 10 || respCycle.size() != 10) begin
            failCount++;
            $display("[TB] FAIL b2b_count: drained=%0b grants=%0d resps=%0d, expected 1 10 10",
                     ok, grantLog.size(), respCycle.size());
        end
        if (grantLog.size() == 10) begin
            for (int i = 1; i < 10; i++) begin
                assertCount++;
`ifdef ARB_ROUND_ROBIN_EN
                if (grantLog[i] === grantLog[i-1]) begin
                    failCount++;
                    $display("[TB] FAIL b2b_order: grant %0d ls=%0b, expected ls=%0b", i, grantLog[i], !grantLog[i-1]);
                end
`else
                if (grantLog[i] !== (i < 5)) begin
                    failCount++;
                    $display("[TB] FAIL b2b_order: grant %0d ls=%0b, expected ls=%0b", i, grantLog[i], (i < 5));
                end
`endif
            end
        end
        for (int i = 1; i < acceptCycle.size(); i++) begin
            assertCount++;
            if (acceptCycle[i] - acceptCycle[i-1] != 3) begin
                failCount++;
                $display("[TB] FAIL b2b_gap: accept %0d gap %0d, expected 3", i, acceptCycle[i] - acceptCycle[i-1]);
            end
        end
    endtask

    task automatic test_stray_resp();
        bit ok;
        memAuto      = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b1;
        memRdata     = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clock);
        #1;
        memRespValid = 1'b0;
        @(negedge clock);
        assertCount++;
        if (busy !== 1'b0 || ifRespValid !== 1'b0 || lsRespValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stray_idle: busy=%b if_resp=%b ls_resp=%b, expected 0 0 0",
                     busy, ifRespValid, lsRespValid);
        end
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 64'h7000, 64'h0, 8'h00);
        memRespValid = 1'b1;
        @(posedge clock);
        #1;
        memRespValid = 1'b0;
        @(negedge clock);
        assertCount++;
        if (busy !== 1'b1 || memReqValid !== 1'b1 || memAddr !== 64'h7000) begin
            failCount++;
            $display("[TB] FAIL stray_issue: busy=%b mem_req_valid=%b addr=%h, expected 1 1 7000",
                     busy, memReqValid, memAddr);
        end
        @(posedge clock);
        #1;
        memReqReady = 1'b1;
        @(posedge clock);
        #1;
        memReqReady  = 1'b0;
        memRespValid = 1'b1;
        memRdata     = memData(64'h7000);
        @(posedge clock);
        #1;
        memRespValid = 1'b0;
        waitDrain(ok);
        assertCount++;
        if (!ok || ifRespRdata !== memData(64'h7000)) begin
            failCount++;
            $display("[TB] FAIL stray_complete: drained=%0b if_resp_rdata=%h, expected 1 %h",
                     ok, ifRespRdata, memData(64'h7000));
        end
    endtask

    task automatic checkOutput();
        // Post-reset output snapshot after an abandoned transaction.
        assertCount++;
        if (busy !== 1'b0 || memReqValid !== 1'b0 || ifRespValid !== 1'b0 || lsRespValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_mid_ctrl: busy=%b mem_req_valid=%b if_resp=%b ls_resp=%b, expected all 0",
                     busy, memReqValid, ifRespValid, lsRespValid);
        end
        assertCount++;
        if (memAddr !== 64'h0 || memWe !== 8'h0 || ifRespRdata !== 64'h0 || lsRespRdata !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL rst_mid_data: addr=%h we=%h if_rdata=%h ls_rdata=%h, expected all 0",
                     memAddr, memWe, ifRespRdata, lsRespRdata);
        end
    endtask

    task automatic test_reset_mid();
        memAuto      = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        applyStimulus(1'b0, 64'h8000, 64'h0, 8'h00);
        memReqReady = 1'b1;
        @(posedge clock);
        #1;
        memReqReady = 1'b0;
        @(negedge clock);
        assertCount++;
        if (busy !== 1'b1 || memReqValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_mid_wait: busy=%b mem_req_valid=%b, expected 1 0", busy, memReqValid);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        sbQ.delete();
        @(posedge clock);
        #1;
        reset        = 1'b0;
        memRespValid = 1'b1;
        memRdata     = memData(64'h8000);
        @(negedge clock);
        checkOutput();
        @(posedge clock);
        #1;
        memRespValid = 1'b0;
        @(negedge clock);
        checkOutput();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        fork
            runCycleCounter();
            runMemModel();
            runAcceptMonitor();
            runRespChecker();
        join_none
        $display("[TB] starting mem_port_arbiter tests");
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_back_to_back();
        test_stray_resp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
